// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and ALU encodings for the multi-cycle control
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps ALU op class and funct to alu_control, flagging unknown funct codes
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  aluop_t               alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTL_W-1:0]  alu_control,
  output logic                 funct_illegal
);
  logic [2:0] ctl;
  // unknown funct falls back to add so the datapath still does something defined
  always_comb begin
    ctl = ALU_ADD;
    funct_illegal = 1'b0;
    if (alu_op == ALUOP_SUB) ctl = ALU_SUB;
    else if (alu_op == ALUOP_FUNCT)
      case (funct)
        FUNCT_W'(F_ADD): ctl = ALU_ADD;
        FUNCT_W'(F_SUB): ctl = ALU_SUB;
        FUNCT_W'(F_AND): ctl = ALU_AND;
        FUNCT_W'(F_OR):  ctl = ALU_OR;
        FUNCT_W'(F_SLT): ctl = ALU_SLT;
        default:         funct_illegal = 1'b1;
      endcase
    alu_control = ALUCTL_W'(ctl);
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore control FSM sequencing the multi-cycle MIPS datapath
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int FUNCT_W       = 6,
  parameter int ALUCTL_W      = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [1:0]          pc_src,
  output logic                pc_en,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);
  state_t state_q, state_d;
  aluop_t alu_op;
  logic [ALUCTL_W-1:0] dec_ctl;
  logic funct_illegal, alu_en, ready;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
  assign ready   = mem_ready || (MEM_HANDSHAKE == 0);
  assign is_r    = opcode == OPCODE_W'(OP_RTYPE);
  assign is_lw   = opcode == OPCODE_W'(OP_LW);
  assign is_sw   = opcode == OPCODE_W'(OP_SW);
  assign is_beq  = opcode == OPCODE_W'(OP_BEQ);
  assign is_bne  = opcode == OPCODE_W'(OP_BNE);
  assign is_addi = opcode == OPCODE_W'(OP_ADDI);
  assign is_j    = opcode == OPCODE_W'(OP_J);
  assign alu_op  = state_q == S_BRANCH ? ALUOP_SUB : state_q == S_EXEC ? ALUOP_FUNCT : ALUOP_ADD;
  assign alu_en  = !reset && (state_q inside {S_FETCH, S_DECODE, S_MEMADR, S_EXEC, S_BRANCH, S_ADDIEX});
  assign alu_control = alu_en ? dec_ctl : '0;
  assign state_dbg = state_q;
  mips_alu_decoder #(.FUNCT_W(FUNCT_W), .ALUCTL_W(ALUCTL_W)) u_alu_dec (
    .alu_op(alu_op),
    .funct(funct),
    .alu_control(dec_ctl),
    .funct_illegal(funct_illegal)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  // next state and Moore outputs; everything is forced low while reset is held
  always_comb begin
    state_d = state_q;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    pc_en = 1'b0;
    illegal_op = 1'b0;
    if (!reset)
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          ir_write = ready;
          pc_en = ready;
          state_d = ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal_op = !(is_lw || is_sw || is_r || is_beq || is_bne || is_addi || is_j);
          state_d = (is_lw || is_sw) ? S_MEMADR :
                    is_r ? S_EXEC :
                    (is_beq || is_bne) ? S_BRANCH :
                    is_addi ? S_ADDIEX :
                    is_j ? S_JUMP : S_FETCH;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d = is_sw ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord = 1'b1;
          state_d = ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          state_d = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord = 1'b1;
          state_d = ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          illegal_op = funct_illegal;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src = 2'b01;
          pc_en = is_bne ? !zero : zero;
          state_d = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS datapath; successor to the single-cycle control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the shared-memory, register-file, ALU and PC enables.
- Adds a memory ready handshake (configurable wait states), BNE, illegal-opcode flagging and a parametrised ALU-control width.

Parameters:
- OPCODE_W, 6, opcode field width (instr[31:26]).
- FUNCT_W, 6, funct field width (instr[5:0]).
- ALUCTL_W, 3, width of the alu_control output.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  instruction opcode from the IR.
- funct  in  FUNCT_W  instruction funct field from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_control  out  ALUCTL_W  ALU operation.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- state_dbg  out  4  current state encoding.

Behaviour:
- Moore FSM, one-hot or binary encoding, reported on state_dbg. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Reset: a clk edge with reset=1 sets state to FETCH. While reset=1, all outputs are 0 except state_dbg, which shows the current state. Reset mid-instruction aborts with no further writes.
- All outputs are combinational from state plus inputs. Any output not listed for a state is 0.
- ready = mem_ready | ~MEM_HANDSHAKE.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu op add, pc_src=00.
  - ir_write and pc_en = ready.
  - Go to DECODE on ready, otherwise hold. PC and IR load exactly once.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu op add.
  - Next state by opcode: lw 100011 and sw 101011 → MEMADR; R-type 000000 → EXEC; beq 000100 and bne 000101 → BRANCH; addi 001000 → ADDIEX; j 000010 → JUMP.
  - Any other opcode: illegal_op=1 this cycle, go to FETCH. The PC has already advanced, so the instruction is skipped.
- MEMADR: alu_src_a=1, alu_src_b=10, alu op add. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR:
  - mem_write=1, iord=1. Hold until ready, then go to FETCH.
  - mem_write stays high for every wait cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu op from funct. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu op sub, pc_src=01.
  - pc_en = zero for beq; pc_en = ~zero for bne. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu op add. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- Latency in cycles, zero wait states: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each mem_ready=0 cycle adds one.
- ALU control values:
  - add → 010, sub → 110.
  - By funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unknown funct → 010 and illegal_op pulses in EXEC.
  - Values are zero-extended when ALUCTL_W > 3.
- mem_ready arriving outside a memory state is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum and encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - ALU op class (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - ALU control codes.
- Sub-module mips_alu_decoder: combinational, maps (alu op class, funct) to alu_control and a funct-illegal flag.
- The FSM state register and output decode stay in the top.

Test Plan:
- Reset held for 2 cycles mid-MEMRD → state_dbg=0 after release; reg_write, mem_write and pc_en stay 0 throughout.
- add (opcode 000000, funct 100000), mem_ready=1 → states 0,1,6,7,0; alu_control=010 in EXEC; reg_write=1 and reg_dst=1 in ALUWB only.
- lw with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles with mem_read=1 and iord=1; MEMWB asserts reg_write and mem_to_reg; total 8 cycles.
- beq with zero=1, then bne with zero=1 → pc_en=1 with pc_src=01 for beq; pc_en=0 for bne.
- Opcode 111111 → illegal_op pulse exactly in DECODE; next state FETCH; no reg_write or mem_write.
- MEM_HANDSHAKE=0, mem_ready tied 0 → sw completes in 4 cycles; mem_write high for 1 cycle.
